// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO with 2-flop input sync, edge capture into a W1C status register, and an irq output.
//   ports: clk, reset (async, active-high); bus stb/rw/addr/dtw -> dtr/ack;
//          pins gpio_in -> gpio_out/gpio_oe; irq = registered |(ISR & IER)
module gpio_mmio #(
  parameter int               NPINS   = 9,
  parameter logic [NPINS-1:0] OUT_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stb,
  input  logic             rw,
  input  logic [4:0]       addr,
  input  logic [31:0]      dtw,
  output logic [31:0]      dtr,
  output logic             ack,
  input  logic [NPINS-1:0] gpio_in,
  output logic [NPINS-1:0] gpio_out,
  output logic [NPINS-1:0] gpio_oe,
  output logic             irq
);
  logic [NPINS-1:0] r_dout, r_dir, r_ier, r_rise, r_fall, r_isr, r_s1, r_s2, r_prev;
  logic [31:0]      r_dtr;
  logic             r_ack, r_irq;
  logic             w_go, w_wr;
  logic [2:0]       w_sel;
  logic [NPINS-1:0] w_wd, w_rd, w_set, w_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;
  // a request arriving while ack is high is ignored, so a held strobe yields one transfer per two cycles
  assign w_go  = stb & ~r_ack;
  assign w_wr  = w_go & rw;
  assign w_sel = addr[4:2];
  assign w_wd  = dtw[NPINS-1:0];
  assign w_set = (r_s2 & ~r_prev & r_rise) | (~r_s2 & r_prev & r_fall);
  assign w_clr = (w_wr && w_sel == 3'd6) ? w_wd : '0;
  assign w_rd  = w_sel == 3'd0 ? r_dout :
                 w_sel == 3'd1 ? r_dir  :
                 w_sel == 3'd2 ? r_s2   :
                 w_sel == 3'd3 ? r_ier  :
                 w_sel == 3'd4 ? r_rise :
                 w_sel == 3'd5 ? r_fall :
                 w_sel == 3'd6 ? r_isr  : '0;
  assign w_unused = ^{addr[1:0], dtw};
  always_comb begin
    w_rdata = '0;
    w_rdata[NPINS-1:0] = w_rd;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= OUT_RST;
      r_dir  <= '0;
      r_ier  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_isr  <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_dtr  <= '0;
      r_ack  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ack  <= w_go;
      r_dtr  <= (w_go && !rw) ? w_rdata : '0;
      r_s1   <= gpio_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_dout <= (w_wr && w_sel == 3'd0) ? w_wd : r_dout;
      r_dir  <= (w_wr && w_sel == 3'd1) ? w_wd : r_dir;
      r_ier  <= (w_wr && w_sel == 3'd3) ? w_wd : r_ier;
      r_rise <= (w_wr && w_sel == 3'd4) ? w_wd : r_rise;
      r_fall <= (w_wr && w_sel == 3'd5) ? w_wd : r_fall;
      // set is ORed after the clear so an edge landing on the same cycle as its W1C is kept
      r_isr  <= (r_isr & ~w_clr) | w_set;
      r_irq  <= |(r_isr & r_ier);
    end
  end
  assign dtr      = r_dtr;
  assign ack      = r_ack;
  assign irq      = r_irq;
  assign gpio_out = r_dout;
  assign gpio_oe  = r_dir;
endmodule

// File: tb/tb_gpio_mmio.sv
// tb_gpio_mmio: table-driven register checks plus directed edge/irq/bus-timing sequences for gpio_mmio.
module tb_gpio_mmio;
  logic        clk = 1'b0, reset = 1'b1, stb = 1'b0, rw = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] dtw = '0, dtr;
  logic        ack, irq;
  logic [8:0]  gpio_in = '0, gpio_out, gpio_oe;
  int          total = 0, bad = 0;
  gpio_mmio dut (
    .clk(clk), .reset(reset), .stb(stb), .rw(rw), .addr(addr), .dtw(dtw), .dtr(dtr), .ack(ack),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        w;
    logic [2:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp;
    logic [8:0]  out;
    logic [8:0]  oe;
  } vec_t;
  vec_t vecs[21];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [2:0] idx, input logic [31:0] wd, output logic [31:0] rd);
    stb = 1'b1;
    rw = w;
    addr = {idx, 2'b00};
    dtw = wd;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    chk("ack", {31'b0, ack}, 32'd1);
    rd = dtr;
  endtask
  task automatic bus(input logic w, input logic [2:0] idx, input logic [31:0] wd, output logic [31:0] rd);
    xfer(w, idx, wd, rd);
    @(negedge clk);
  endtask
  task automatic rd_chk(input string nm, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, idx, 32'h0, d);
    chk(nm, d, exp);
  endtask
  task automatic wr(input logic [2:0] idx, input logic [31:0] wd);
    logic [31:0] d;
    bus(1'b1, idx, wd, d);
  endtask
  function automatic vec_t mk(input logic w, input logic [2:0] idx, input logic [31:0] wd,
                              input logic [31:0] exp, input logic [8:0] out, input logic [8:0] oe);
    mk = '{w, idx, wd, exp, out, oe};
  endfunction
  initial begin
    logic [31:0] d;
    int n;
    vecs[0]  = mk(1, 0, 32'h1A5,      0,       9'h1A5, 9'h000);
    vecs[1]  = mk(1, 1, 32'h0FF,      0,       9'h1A5, 9'h0FF);
    vecs[2]  = mk(0, 0, 0,            32'h1A5, 9'h1A5, 9'h0FF);
    vecs[3]  = mk(0, 1, 0,            32'h0FF, 9'h1A5, 9'h0FF);
    vecs[4]  = mk(1, 0, 32'hFFFFFFFF, 0,       9'h1FF, 9'h0FF);
    vecs[5]  = mk(0, 0, 0,            32'h1FF, 9'h1FF, 9'h0FF);
    vecs[6]  = mk(1, 2, 32'h1FF,      0,       9'h1FF, 9'h0FF);
    vecs[7]  = mk(0, 2, 0,            32'h000, 9'h1FF, 9'h0FF);
    vecs[8]  = mk(1, 7, 32'hFFFFFFFF, 0,       9'h1FF, 9'h0FF);
    vecs[9]  = mk(0, 7, 0,            32'h000, 9'h1FF, 9'h0FF);
    vecs[10] = mk(1, 3, 32'hFFFFFE00, 0,       9'h1FF, 9'h0FF);
    vecs[11] = mk(0, 3, 0,            32'h000, 9'h1FF, 9'h0FF);
    vecs[12] = mk(1, 4, 32'h3FF,      0,       9'h1FF, 9'h0FF);
    vecs[13] = mk(0, 4, 0,            32'h1FF, 9'h1FF, 9'h0FF);
    vecs[14] = mk(1, 5, 32'h0A5,      0,       9'h1FF, 9'h0FF);
    vecs[15] = mk(0, 5, 0,            32'h0A5, 9'h1FF, 9'h0FF);
    vecs[16] = mk(1, 4, 32'h001,      0,       9'h1FF, 9'h0FF);
    vecs[17] = mk(1, 5, 32'h000,      0,       9'h1FF, 9'h0FF);
    vecs[18] = mk(1, 3, 32'h001,      0,       9'h1FF, 9'h0FF);
    vecs[19] = mk(1, 0, 32'h1A5,      0,       9'h1A5, 9'h0FF);
    vecs[20] = mk(0, 6, 0,            32'h000, 9'h1A5, 9'h0FF);
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_dtr", dtr, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_out", {23'b0, gpio_out}, 0);
    chk("rst_oe", {23'b0, gpio_oe}, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      bus(vecs[i].w, vecs[i].idx, vecs[i].wd, d);
      if (!vecs[i].w) chk($sformatf("vec%0d_dtr", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_out", i), {23'b0, gpio_out}, {23'b0, vecs[i].out});
      chk($sformatf("vec%0d_oe", i), {23'b0, gpio_oe}, {23'b0, vecs[i].oe});
    end
    gpio_in[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    xfer(0, 2, 0, d);
    chk("din_early", d, 0);
    @(negedge clk);
    chk("irq_early", {31'b0, irq}, 0);
    xfer(0, 6, 0, d);
    chk("isr_at3", d, 32'h001);
    chk("irq_at4", {31'b0, irq}, 1);
    @(negedge clk);
    xfer(1, 6, 32'h001, d);
    @(negedge clk);
    chk("irq_w1c", {31'b0, irq}, 0);
    rd_chk("isr_w1c", 6, 0);
    rd_chk("din_pin0", 2, 32'h001);
    gpio_in[8] = 1'b1;
    repeat (4) @(negedge clk);
    wr(5, 32'h100);
    wr(3, 32'h000);
    gpio_in[8] = 1'b0;
    repeat (5) @(negedge clk);
    rd_chk("isr_fall8", 6, 32'h100);
    chk("irq_masked", {31'b0, irq}, 0);
    xfer(1, 3, 32'h100, d);
    chk("irq_ier_ack", {31'b0, irq}, 0);
    @(negedge clk);
    chk("irq_ier_late", {31'b0, irq}, 1);
    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("isr_pend", 6, 32'h101);
    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus(1, 6, 32'h101, d);
    rd_chk("isr_setwins", 6, 32'h001);
    n = 0;
    stb = 1'b1;
    rw = 1'b0;
    addr = {3'd2, 2'b00};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("held_ack%0d", i), {31'b0, ack}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("held_dtr%0d", i), dtr, (i % 2 == 0) ? 32'h001 : 0);
      n += int'(ack);
    end
    stb = 1'b0;
    chk("held_acks", n, 3);
    @(negedge clk);
    wr(3, 32'h001);
    repeat (2) @(negedge clk);
    chk("irq_pre_rst", {31'b0, irq}, 1);
    stb = 1'b1;
    rw = 1'b0;
    addr = 5'd0;
    @(posedge clk);
    #2;
    chk("ack_pre_rst", {31'b0, ack}, 1);
    reset = 1'b1;
    #1;
    chk("mid_ack", {31'b0, ack}, 0);
    chk("mid_dtr", dtr, 0);
    chk("mid_irq", {31'b0, irq}, 0);
    chk("mid_out", {23'b0, gpio_out}, 0);
    chk("mid_oe", {23'b0, gpio_oe}, 0);
    stb = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("post_rst_reg%0d", i), 3'(i), (i == 2) ? 32'h001 : 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
